// File: rtl/psram_define.sv
// Command codes and FSM state encoding shared by the QPI PSRAM responder and its benches.
package psram_define;

    localparam logic [7:0] PSRAM_CMD_QRD   = 8'hEB;
    localparam logic [7:0] PSRAM_CMD_QWR   = 8'h38;
    localparam logic [7:0] PSRAM_CMD_RSTEN = 8'h66;
    localparam logic [7:0] PSRAM_CMD_RST   = 8'h99;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_RDATA,
        S_WDATA,
        S_DROP
    } psram_state_t;

endpackage

// File: rtl/psram_resp_if.sv
// Single-port byte memory bus between the PSRAM responder (master) and the backing memory (slave).
interface psram_resp_if #(
    parameter int AW = 24
);
    // mem_re / mem_we are one-cycle strobes with no ready: the memory accepts every
    // strobe in the cycle it is high, and mem_rdata is valid in the cycle after mem_re.
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic          mem_re;
    logic [7:0]    mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/psram_sync.sv
// Two-flop synchronizers for the PSRAM pins plus rise/fall pulses on the synchronized SCK.
module psram_sync (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sck_i,
    input  logic       ce_n_i,
    input  logic [3:0] io_i,
    output logic       ce_n_o,
    output logic [3:0] io_o,
    output logic       sck_rise_o,
    output logic       sck_fall_o
);
    logic [1:0] sck_ff;
    logic [1:0] ce_ff;
    logic [3:0] io_ff1;
    logic [3:0] io_ff2;
    logic       sck_d;

    // ce_n resets high so a reset never looks like the start of a frame.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_ff <= 2'b00;
            ce_ff  <= 2'b11;
            io_ff1 <= 4'h0;
            io_ff2 <= 4'h0;
            sck_d  <= 1'b0;
        end else begin
            sck_ff <= {sck_ff[0], sck_i};
            ce_ff  <= {ce_ff[0], ce_n_i};
            io_ff1 <= io_i;
            io_ff2 <= io_ff1;
            sck_d  <= sck_ff[1];
        end
    end

    assign ce_n_o     = ce_ff[1];
    assign io_o       = io_ff2;
    assign sck_rise_o = sck_ff[1] & ~sck_d;
    assign sck_fall_o = ~sck_ff[1] & sck_d;

endmodule

// File: rtl/psram_resp.sv
// QPI PSRAM device responder: oversamples the serial link on clk_i and turns
// quad read/write frames into byte strobes on a single-port memory bus.
module psram_resp
    import psram_define::*;
#(
    parameter int AW       = 24,
    parameter int WAIT_CYC = 6
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          psram_sck_i,
    input  logic          psram_ce_n_i,
    input  logic [3:0]    psram_io_i,
    output logic [3:0]    psram_io_o,
    output logic          psram_io_en_o,
    psram_resp_if.master  mem,
    output logic          busy_o,
    output logic          rst_evt_o,
    output psram_state_t  state_o
);
    logic       ce_n_s;
    logic [3:0] io_s;
    logic       sck_rise;
    logic       sck_fall;

    psram_sync u_sync (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .sck_i      (psram_sck_i),
        .ce_n_i     (psram_ce_n_i),
        .io_i       (psram_io_i),
        .ce_n_o     (ce_n_s),
        .io_o       (io_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall)
    );

    psram_state_t  state_q;
    logic [7:0]    cnt_q;
    logic [19:0]   nib_q;
    logic [7:0]    cmd_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    rbyte_q;
    logic          hi_q;
    logic [3:0]    wnib_q;
    logic [3:0]    io_q;
    logic          io_en_q;
    logic          we_q;
    logic          re_q;
    logic          re_d_q;
    logic [7:0]    wdata_q;
    logic          busy_q;
    logic          evt_q;
    logic          flag_q;

    logic [23:0] addr_full;
    logic [7:0]  cmd_full;

    assign addr_full = {nib_q, io_s};
    assign cmd_full  = {nib_q[3:0], io_s};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nib_q   <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            rbyte_q <= '0;
            hi_q    <= 1'b1;
            wnib_q  <= '0;
            io_q    <= '0;
            io_en_q <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            re_d_q  <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            evt_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            evt_q  <= 1'b0;
            re_d_q <= re_q;
            busy_q <= ~ce_n_s;
            if (re_d_q) rbyte_q <= mem.mem_rdata;
            // Post-increment after each write strobe so the strobe cycle sees the old address.
            if (we_q) addr_q <= addr_q + AW'(1);

            if (ce_n_s) begin
                state_q <= S_IDLE;
                io_en_q <= 1'b0;
                hi_q    <= 1'b1;
                cnt_q   <= '0;
                // Reset-enable/reset commands take effect only once their frame has closed.
                if (state_q == S_DROP) begin
                    if (cmd_q == PSRAM_CMD_RSTEN) begin
                        flag_q <= 1'b1;
                    end else begin
                        evt_q  <= flag_q && (cmd_q == PSRAM_CMD_RST);
                        flag_q <= 1'b0;
                    end
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_CMD;
                        cnt_q   <= '0;
                        hi_q    <= 1'b1;
                    end
                    S_CMD: if (sck_rise) begin
                        if (cnt_q == 8'd0) begin
                            nib_q <= {nib_q[15:0], io_s};
                            cnt_q <= 8'd1;
                        end else begin
                            cmd_q <= cmd_full;
                            cnt_q <= '0;
                            case (cmd_full)
                                PSRAM_CMD_QRD, PSRAM_CMD_QWR: begin
                                    state_q <= S_ADDR;
                                    flag_q  <= 1'b0;
                                end
                                default: state_q <= S_DROP;
                            endcase
                        end
                    end
                    S_ADDR: if (sck_rise) begin
                        if (cnt_q == 8'd5) begin
                            addr_q <= addr_full[AW-1:0];
                            cnt_q  <= '0;
                            hi_q   <= 1'b1;
                            if (cmd_q == PSRAM_CMD_QRD) begin
                                state_q <= S_WAIT;
                                re_q    <= 1'b1;
                            end else begin
                                state_q <= S_WDATA;
                            end
                        end else begin
                            nib_q <= {nib_q[15:0], io_s};
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_WAIT: if (sck_rise) begin
                        if (cnt_q == 8'(WAIT_CYC - 1)) begin
                            state_q <= S_RDATA;
                            hi_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_RDATA: if (sck_fall) begin
                        if (hi_q) begin
                            io_q    <= rbyte_q[7:4];
                            io_en_q <= 1'b1;
                            hi_q    <= 1'b0;
                        end else begin
                            io_q   <= rbyte_q[3:0];
                            addr_q <= addr_q + AW'(1);
                            re_q   <= 1'b1;
                            hi_q   <= 1'b1;
                        end
                    end
                    S_WDATA: if (sck_rise) begin
                        if (hi_q) begin
                            wnib_q <= io_s;
                            hi_q   <= 1'b0;
                        end else begin
                            wdata_q <= {wnib_q, io_s};
                            we_q    <= 1'b1;
                            hi_q    <= 1'b1;
                        end
                    end
                    S_DROP: ;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign psram_io_o    = io_q;
    assign psram_io_en_o = io_en_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_re    = re_q;
    assign busy_o        = busy_q;
    assign rst_evt_o     = evt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_psram_resp.sv
// Bench for psram_resp: a 24-bit and an 8-bit address instance share one host driver.
module tb_psram_resp;
    import psram_define::*;

    localparam int HALF = 6;

    typedef struct {
        logic [7:0] cmd;
        int         exp_evt;
    } rst_vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck   = 1'b0;
    logic       ce_n  = 1'b1;
    logic [3:0] io    = 4'h0;

    logic [3:0]   io_o24, io_o8;
    logic         io_en24, io_en8, busy24, busy8, evt24_o, evt8_o;
    psram_state_t st24, st8;

    psram_resp_if #(.AW(24)) m24 ();
    psram_resp_if #(.AW(8))  m8 ();

    psram_resp #(.AW(24), .WAIT_CYC(6)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .psram_sck_i(sck), .psram_ce_n_i(ce_n),
        .psram_io_i(io), .psram_io_o(io_o24), .psram_io_en_o(io_en24), .mem(m24),
        .busy_o(busy24), .rst_evt_o(evt24_o), .state_o(st24)
    );

    psram_resp #(.AW(8), .WAIT_CYC(6)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .psram_sck_i(sck), .psram_ce_n_i(ce_n),
        .psram_io_i(io), .psram_io_o(io_o8), .psram_io_en_o(io_en8), .mem(m8),
        .busy_o(busy8), .rst_evt_o(evt8_o), .state_o(st8)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int evt24 = 0, evt8 = 0, wr24 = 0, wr8 = 0;

    logic [31:0] exp24_q[$];
    logic [15:0] exp8_q[$];
    logic [31:0] e24m;
    logic [15:0] e8m;

    logic [7:0] ram24 [int];
    logic [7:0] ram8  [int];
    logic [7:0] ref24 [int];
    logic [7:0] ref8  [int];
    logic [7:0] wbuf  [8];

    logic [3:0] smp24, smp8;
    logic       sen24, sen8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Unwritten locations read back a fixed pattern derived from the address.
    function automatic logic [7:0] fill(input int a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input int which, input int a);
        case (which)
            0:       return ram24.exists(a) ? ram24[a] : fill(a);
            1:       return ram8.exists(a)  ? ram8[a]  : fill(a);
            2:       return ref24.exists(a) ? ref24[a] : fill(a);
            default: return ref8.exists(a)  ? ref8[a]  : fill(a);
        endcase
    endfunction

    // Backing memories plus the write scoreboard.
    always @(posedge clk) begin
        if (m24.mem_re) m24.mem_rdata <= mem_rd(0, int'(m24.mem_addr));
        if (m8.mem_re)  m8.mem_rdata  <= mem_rd(1, int'(m8.mem_addr));
        if (rst_n) begin
            if (evt24_o) evt24++;
            if (evt8_o)  evt8++;
            if (m24.mem_we || m24.mem_re) chk("we_re_excl24", 32'(m24.mem_we && m24.mem_re), 32'd0);
            if (m8.mem_we || m8.mem_re)   chk("we_re_excl8", 32'(m8.mem_we && m8.mem_re), 32'd0);
            if (m24.mem_we) begin
                ram24[int'(m24.mem_addr)] = m24.mem_wdata;
                wr24++;
                chk("wr24_expected", 32'(exp24_q.size() > 0), 32'd1);
                if (exp24_q.size() > 0) begin
                    e24m = exp24_q.pop_front();
                    chk("wr24_addr_data", {m24.mem_addr, m24.mem_wdata}, e24m);
                end
            end
            if (m8.mem_we) begin
                ram8[int'(m8.mem_addr)] = m8.mem_wdata;
                wr8++;
                chk("wr8_expected", 32'(exp8_q.size() > 0), 32'd1);
                if (exp8_q.size() > 0) begin
                    e8m = exp8_q.pop_front();
                    chk("wr8_addr_data", 32'({m8.mem_addr, m8.mem_wdata}), 32'(e8m));
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] nib);
        io = nib;
        clks(HALF);
        sck   = 1'b1;
        smp24 = io_o24;
        smp8  = io_o8;
        sen24 = io_en24;
        sen8  = io_en8;
        clks(HALF);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse(b[7:4]);
        pulse(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 0; i < 6; i++) pulse(a[23-4*i -: 4]);
    endtask

    task automatic frame_begin;
        ce_n = 1'b0;
        clks(4);
        chk("busy24_in_frame", 32'(busy24), 32'd1);
        chk("busy8_in_frame", 32'(busy8), 32'd1);
    endtask

    task automatic frame_end;
        clks(2);
        ce_n = 1'b1;
        clks(8);
        chk("io_en24_after_frame", 32'(io_en24), 32'd0);
        chk("io_en8_after_frame", 32'(io_en8), 32'd0);
        chk("state24_idle", 32'(st24), 32'(S_IDLE));
        chk("state8_idle", 32'(st8), 32'(S_IDLE));
        chk("busy24_after_frame", 32'(busy24), 32'd0);
    endtask

    task automatic push_wr(input logic [23:0] a, input int i, input logic [7:0] d);
        int a24;
        int a8;
        a24 = (int'(a) + i) % 16777216;
        a8  = (int'(a) + i) % 256;
        ref24[a24] = d;
        ref8[a8]   = d;
        exp24_q.push_back({a24[23:0], d});
        exp8_q.push_back({a8[7:0], d});
    endtask

    task automatic do_write(input logic [23:0] a, input int n);
        frame_begin;
        send_byte(PSRAM_CMD_QWR);
        send_addr(a);
        for (int i = 0; i < n; i++) begin
            push_wr(a, i, wbuf[i]);
            send_byte(wbuf[i]);
        end
        frame_end;
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic       en_seen;
        logic [7:0] x24;
        logic [7:0] x8;
        frame_begin;
        send_byte(PSRAM_CMD_QRD);
        send_addr(a);
        en_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse(4'h0);
            en_seen = en_seen | sen24 | sen8;
        end
        chk("io_en_low_in_dummy", 32'(en_seen), 32'd0);
        for (int i = 0; i < n; i++) begin
            x24 = mem_rd(2, (int'(a) + i) % 16777216);
            x8  = mem_rd(3, (int'(a) + i) % 256);
            pulse(4'h0);
            chk("rd24_hi", 32'({sen24, smp24}), 32'({1'b1, x24[7:4]}));
            chk("rd8_hi", 32'({sen8, smp8}), 32'({1'b1, x8[7:4]}));
            pulse(4'h0);
            chk("rd24_lo", 32'({sen24, smp24}), 32'({1'b1, x24[3:0]}));
            chk("rd8_lo", 32'({sen8, smp8}), 32'({1'b1, x8[3:0]}));
        end
        frame_end;
    endtask

    initial begin
        rst_vec_t   rv [15];
        int         b24, b8, r, n;
        logic [23:0] a;

        rv[0]  = '{8'h66, 0};  rv[1]  = '{8'h99, 1};  rv[2]  = '{8'h99, 0};
        rv[3]  = '{8'h66, 0};  rv[4]  = '{8'hEB, 0};  rv[5]  = '{8'h99, 0};
        rv[6]  = '{8'h66, 0};  rv[7]  = '{8'h66, 0};  rv[8]  = '{8'h99, 1};
        rv[9]  = '{8'h66, 0};  rv[10] = '{8'h5A, 0};  rv[11] = '{8'h99, 0};
        rv[12] = '{8'h66, 0};  rv[13] = '{8'h38, 0};  rv[14] = '{8'h99, 0};

        // Reset values
        clks(3);
        chk("rst_io_o", 32'(io_o24), 32'd0);
        chk("rst_io_en", 32'(io_en24), 32'd0);
        chk("rst_mem_addr", 32'(m24.mem_addr), 32'd0);
        chk("rst_mem_we", 32'(m24.mem_we), 32'd0);
        chk("rst_mem_re", 32'(m24.mem_re), 32'd0);
        chk("rst_mem_wdata", 32'(m24.mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy24), 32'd0);
        chk("rst_evt", 32'(evt24_o), 32'd0);
        chk("rst_state", 32'(st24), 32'(S_IDLE));
        rst_n = 1'b1;
        clks(4);

        // Directed write then read back at 0x10
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        do_write(24'h000010, 2);
        do_read(24'h000010, 2);

        // Wrap: 0xFF is followed by 0x00 on the 8-bit instance
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(24'h0000FF, 2);
        do_read(24'h0000FF, 2);

        // Write aborted after three nibbles: one strobe only
        b24 = wr24; b8 = wr8;
        frame_begin;
        send_byte(PSRAM_CMD_QWR);
        send_addr(24'h000040);
        push_wr(24'h000040, 0, 8'hC3);
        pulse(4'hC); pulse(4'h3); pulse(4'h7);
        frame_end;
        chk("abort_wr24_count", 32'(wr24 - b24), 32'd1);
        chk("abort_wr8_count", 32'(wr8 - b8), 32'd1);
        do_read(24'h000040, 2);

        // Read aborted after the first data nibble
        frame_begin;
        send_byte(PSRAM_CMD_QRD);
        send_addr(24'h000010);
        for (int i = 0; i < 6; i++) pulse(4'h0);
        pulse(4'h0);
        chk("abort_rd_en_before", 32'(sen24), 32'd1);
        frame_end;

        // Reset-enable / reset command table
        for (int i = 0; i < 15; i++) begin
            b24 = evt24; b8 = evt8;
            frame_begin;
            send_byte(rv[i].cmd);
            frame_end;
            chk($sformatf("rst_evt24_row%0d", i), 32'(evt24 - b24), 32'(rv[i].exp_evt));
            chk($sformatf("rst_evt8_row%0d", i), 32'(evt8 - b8), 32'(rv[i].exp_evt));
        end

        // Randomized frames against the reference memories
        for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 2);
            a = 24'($urandom);
            if (r == 0) a[7:0] = 8'hFC + 8'($urandom_range(0, 3));
            if (r == 1) a = 24'hFFFFFE;
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(a, n);
            end
            do_read(a, n);
        end

        // Asynchronous reset in the middle of a read
        frame_begin;
        send_byte(PSRAM_CMD_QRD);
        send_addr(24'h000010);
        for (int i = 0; i < 6; i++) pulse(4'h0);
        pulse(4'h0);
        chk("pre_reset_io_en", 32'(sen24), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_io_o", 32'(io_o24), 32'd0);
        chk("arst_io_en", 32'(io_en24), 32'd0);
        chk("arst_mem_addr", 32'(m24.mem_addr), 32'd0);
        chk("arst_mem_we", 32'(m24.mem_we), 32'd0);
        chk("arst_mem_re", 32'(m24.mem_re), 32'd0);
        chk("arst_mem_wdata", 32'(m24.mem_wdata), 32'd0);
        chk("arst_busy", 32'(busy24), 32'd0);
        chk("arst_evt", 32'(evt24_o), 32'd0);
        chk("arst_state", 32'(st24), 32'(S_IDLE));
        ce_n = 1'b1;
        sck  = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        wbuf[0] = 8'h9E; wbuf[1] = 8'h47;
        do_write(24'h000123, 2);
        do_read(24'h000123, 2);

        clks(10);
        chk("exp24_q_drained", 32'(exp24_q.size()), 32'd0);
        chk("exp8_q_drained", 32'(exp8_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got still running expected finished by %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
